// File: rtl/trdb_pkg.sv
// Shared trace-debugger definitions: bus width and the trace FIFO flush state type.
package trdb_pkg;

    parameter int unsigned BUS_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        TRDB_FLUSH_IDLE  = 2'd0,
        TRDB_FLUSH_DRAIN = 2'd1,
        TRDB_FLUSH_DONE  = 2'd2
    } trdb_fifo_flush_e;

endpackage : trdb_pkg

// File: rtl/trdb_trace_fifo.sv
// Show-ahead trace FIFO between the stream aligner and the bus writer, with
// lossy overflow accounting and a flush-drain handshake.
module trdb_trace_fifo
    import trdb_pkg::*;
#(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned DROP_CNT_W = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      clear_i,
    input  logic [BUS_DATA_WIDTH-1:0] data_i,
    input  logic                      valid_i,
    input  logic                      flush_i,
    output logic [BUS_DATA_WIDTH-1:0] data_o,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic                      flush_done_o,
    output logic [$clog2(DEPTH):0]    fill_level_o,
    output logic                      overflow_o,
    output logic [DROP_CNT_W-1:0]     drop_count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [BUS_DATA_WIDTH-1:0] mem_r [DEPTH];

    logic [PW-1:0]             wr_ptr_r;
    logic [PW-1:0]             rd_ptr_r;
    logic [PW-1:0]             fill_r;
    logic                      valid_r;
    logic [BUS_DATA_WIDTH-1:0] data_r;
    logic                      flush_done_r;
    logic                      overflow_r;
    logic [DROP_CNT_W-1:0]     drop_cnt_r;
    trdb_fifo_flush_e          flush_r;

    logic                      empty_s;
    logic                      full_s;
    logic                      pop_s;
    logic                      push_s;
    logic                      drop_s;
    logic [PW-1:0]             wr_next_s;
    logic [PW-1:0]             rd_next_s;
    logic [PW-1:0]             fill_next_s;
    logic [BUS_DATA_WIDTH-1:0] data_next_s;
    logic [DROP_CNT_W-1:0]     drop_cnt_next_s;
    trdb_fifo_flush_e          flush_next_s;

    // Pointer-derived status and the push/pop/drop decision for this cycle.
    always_comb begin
        empty_s = (wr_ptr_r == rd_ptr_r);
        full_s  = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) && (wr_ptr_r[AW] != rd_ptr_r[AW]);
        pop_s   = valid_r && ready_i;
        push_s  = valid_i && (!full_s || pop_s);
        drop_s  = valid_i && full_s && !pop_s;
    end

    // Next pointer values and the level/head word they imply.
    always_comb begin
        wr_next_s   = wr_ptr_r;
        rd_next_s   = rd_ptr_r;
        data_next_s = data_r;
        if (push_s) begin
            wr_next_s = wr_ptr_r + PW'(1);
        end else begin
            wr_next_s = wr_ptr_r;
        end
        if (pop_s) begin
            rd_next_s = rd_ptr_r + PW'(1);
        end else begin
            rd_next_s = rd_ptr_r;
        end
        fill_next_s = wr_next_s - rd_next_s;
        // The new head may be the word being written at this same edge.
        if (push_s && (wr_ptr_r[AW-1:0] == rd_next_s[AW-1:0])) begin
            data_next_s = data_i;
        end else begin
            data_next_s = mem_r[rd_next_s[AW-1:0]];
        end
    end

    // Saturating dropped-word counter.
    always_comb begin
        drop_cnt_next_s = drop_cnt_r;
        if (drop_s && (drop_cnt_r != {DROP_CNT_W{1'b1}})) begin
            drop_cnt_next_s = drop_cnt_r + DROP_CNT_W'(1);
        end else begin
            drop_cnt_next_s = drop_cnt_r;
        end
    end

    // Flush handshake: wait until every word seen so far has left the FIFO.
    always_comb begin
        flush_next_s = flush_r;
        case (flush_r)
            TRDB_FLUSH_IDLE: begin
                if (flush_i) begin
                    flush_next_s = TRDB_FLUSH_DRAIN;
                end else begin
                    flush_next_s = TRDB_FLUSH_IDLE;
                end
            end
            TRDB_FLUSH_DRAIN: begin
                if ((fill_next_s == {PW{1'b0}}) && !valid_i) begin
                    flush_next_s = TRDB_FLUSH_DONE;
                end else begin
                    flush_next_s = TRDB_FLUSH_DRAIN;
                end
            end
            TRDB_FLUSH_DONE: begin
                flush_next_s = TRDB_FLUSH_IDLE;
            end
            default: begin
                flush_next_s = TRDB_FLUSH_IDLE;
            end
        endcase
    end

    // Storage array; contents are never reset, only the pointers are.
    always_ff @(posedge clk_i) begin
        if (push_s && !clear_i) begin
            mem_r[wr_ptr_r[AW-1:0]] <= data_i;
        end
    end

    // Pointers and registered output view of the FIFO.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            fill_r   <= {PW{1'b0}};
            valid_r  <= 1'b0;
            data_r   <= {BUS_DATA_WIDTH{1'b0}};
        end else if (clear_i) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            fill_r   <= {PW{1'b0}};
            valid_r  <= 1'b0;
            data_r   <= {BUS_DATA_WIDTH{1'b0}};
        end else begin
            wr_ptr_r <= wr_next_s;
            rd_ptr_r <= rd_next_s;
            fill_r   <= fill_next_s;
            valid_r  <= (wr_next_s != rd_next_s);
            data_r   <= data_next_s;
        end
    end

    // Sticky overflow flag and dropped-word count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overflow_r <= 1'b0;
            drop_cnt_r <= {DROP_CNT_W{1'b0}};
        end else if (clear_i) begin
            overflow_r <= 1'b0;
            drop_cnt_r <= {DROP_CNT_W{1'b0}};
        end else begin
            overflow_r <= overflow_r | drop_s;
            drop_cnt_r <= drop_cnt_next_s;
        end
    end

    // Flush state register and its one-cycle completion pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            flush_r      <= TRDB_FLUSH_IDLE;
            flush_done_r <= 1'b0;
        end else if (clear_i) begin
            flush_r      <= TRDB_FLUSH_IDLE;
            flush_done_r <= 1'b0;
        end else begin
            flush_r      <= flush_next_s;
            flush_done_r <= (flush_next_s == TRDB_FLUSH_DONE);
        end
    end

    assign data_o       = data_r;
    assign valid_o      = valid_r;
    assign fill_level_o = fill_r;
    assign flush_done_o = flush_done_r;
    assign overflow_o   = overflow_r;
    assign drop_count_o = drop_cnt_r;

endmodule : trdb_trace_fifo

// File: tb/tb_trdb_trace_fifo.sv
// Directed and randomized bench for trdb_trace_fifo (DEPTH=4) against a
// queue-based reference model of the FIFO, drop accounting and flush handshake.
module tb_trdb_trace_fifo;
    import trdb_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned DCW   = 16;

    logic                      clk;
    logic                      rst_ni;
    logic                      clear_i;
    logic [BUS_DATA_WIDTH-1:0] data_i;
    logic                      valid_i;
    logic                      flush_i;
    logic [BUS_DATA_WIDTH-1:0] data_o;
    logic                      valid_o;
    logic                      ready_i;
    logic                      flush_done_o;
    logic [$clog2(DEPTH):0]    fill_level_o;
    logic                      overflow_o;
    logic [DCW-1:0]            drop_count_o;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [BUS_DATA_WIDTH-1:0] mq[$];
    int  m_drops;
    bit  m_ovf;
    int  m_phase;     // 0 waiting for flush, 1 draining, 2 completion pulse
    int  done_pulses;

    trdb_trace_fifo #(.DEPTH(DEPTH), .DROP_CNT_W(DCW)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .clear_i      (clear_i),
        .data_i       (data_i),
        .valid_i      (valid_i),
        .flush_i      (flush_i),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .flush_done_o (flush_done_o),
        .fill_level_o (fill_level_o),
        .overflow_o   (overflow_o),
        .drop_count_o (drop_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_drops = 0;
        m_ovf   = 1'b0;
        m_phase = 0;
    endtask

    task automatic model_step(input logic v, input logic [BUS_DATA_WIDTH-1:0] d,
                              input logic r, input logic f, input logic c);
        bit was_full;
        bit popped;
        if (!rst_ni || c) begin
            model_reset();
        end else begin
            was_full = (mq.size() == DEPTH);
            popped   = (mq.size() > 0) && r;
            if (popped) void'(mq.pop_front());
            if (v) begin
                if (!was_full || popped) mq.push_back(d);
                else begin
                    m_ovf = 1'b1;
                    if (m_drops < 65535) m_drops++;
                end
            end
            if (m_phase == 0) m_phase = f ? 1 : 0;
            else if (m_phase == 1) m_phase = (mq.size() == 0 && !v) ? 2 : 1;
            else m_phase = 0;
        end
    endtask

    task automatic check_all();
        chk("valid", valid_o, (mq.size() > 0));
        chk("fill", fill_level_o, mq.size());
        chk("ovf", overflow_o, m_ovf);
        chk("drops", drop_count_o, m_drops);
        chk("flush_done", flush_done_o, (m_phase == 2));
        if (mq.size() > 0) chk("data", data_o, mq[0]);
        if (flush_done_o === 1'b1) done_pulses++;
    endtask

    task automatic cyc(input logic v, input logic [BUS_DATA_WIDTH-1:0] d,
                       input logic r, input logic f, input logic c);
        valid_i = v; data_i = d; ready_i = r; flush_i = f; clear_i = c;
        @(posedge clk);
        model_step(v, d, r, f, c);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [BUS_DATA_WIDTH-1:0] w;
        int pulses_before;
        rst_ni = 1'b0; clear_i = 1'b0; data_i = 32'h0; valid_i = 1'b0;
        flush_i = 1'b0; ready_i = 1'b0;
        model_reset();
        done_pulses = 0;
        #12;
        chk("rst_valid", valid_o, 1'b0);
        chk("rst_fill", fill_level_o, 3'd0);
        chk("rst_drops", drop_count_o, 16'd0);
        chk("rst_ovf", overflow_o, 1'b0);
        chk("rst_done", flush_done_o, 1'b0);
        rst_ni = 1'b1;
        idle(2);

        // Fill then drain in order
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'hA0 + i, 1'b0, 1'b0, 1'b0);
        chk("fill4_level", fill_level_o, 3'd4);
        chk("fill4_valid", valid_o, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk("drain_order", data_o, 32'hA0 + i);
            cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        end
        chk("drain_empty", valid_o, 1'b0);

        // Overflow while full and stalled
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'hD0 + i, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'hB0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'hB1, 1'b0, 1'b0, 1'b0);
        chk("ovf_drops", drop_count_o, 16'd2);
        chk("ovf_flag", overflow_o, 1'b1);
        chk("ovf_head", data_o, 32'hD0);
        chk("ovf_level", fill_level_o, 3'd4);

        // Push into a full FIFO while popping: accepted, level unchanged
        cyc(1'b1, 32'hC0, 1'b1, 1'b0, 1'b0);
        chk("fullpop_level", fill_level_o, 3'd4);
        chk("fullpop_drops", drop_count_o, 16'd2);
        for (int i = 0; i < 3; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("fullpop_last", data_o, 32'hC0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("fullpop_empty", valid_o, 1'b0);
        chk("pop_keeps_ovf", overflow_o, 1'b1);

        // Flush with an extra word arriving during drain
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'hE0 + i, 1'b0, 1'b0, 1'b0);
        pulses_before = done_pulses;
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 32'hE3, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
            chk("flush_early", flush_done_o, 1'b0);
        end
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("flush_after4", flush_done_o, 1'b1);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("flush_onecycle", flush_done_o, 1'b0);
        idle(2);
        chk("flush_pulses", done_pulses - pulses_before, 1);

        // Flush on an already empty FIFO
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        chk("eflush_c1", flush_done_o, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("eflush_c2", flush_done_o, 1'b1);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("eflush_c3", flush_done_o, 1'b0);

        // Wrap the pointers twice, overflow, then clear with a concurrent word
        for (int i = 0; i < 10; i++) cyc(1'b1, 32'h100 + i, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b1, 32'h200 + i, 1'b0, 1'b0, 1'b0);
        chk("wrap_drops", drop_count_o, 16'd2);
        cyc(1'b1, 32'h300, 1'b1, 1'b1, 1'b1);
        chk("clr_level", fill_level_o, 3'd0);
        chk("clr_drops", drop_count_o, 16'd0);
        chk("clr_ovf", overflow_o, 1'b0);
        chk("clr_valid", valid_o, 1'b0);
        idle(3);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            w = $urandom;
            cyc(($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0, w,
                ($urandom_range(0, 99) < 45) ? 1'b1 : 1'b0,
                ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
                ($urandom_range(0, 79) == 0) ? 1'b1 : 1'b0);
        end
        idle(6);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

        // Reset asserted in the middle of a drain
        cyc(1'b1, 32'hF0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'hF1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        pulses_before = done_pulses;
        #3;
        rst_ni = 1'b0;
        #1;
        model_reset();
        chk("mrst_valid", valid_o, 1'b0);
        chk("mrst_fill", fill_level_o, 3'd0);
        chk("mrst_done", flush_done_o, 1'b0);
        chk("mrst_ovf", overflow_o, 1'b0);
        chk("mrst_drops", drop_count_o, 16'd0);
        idle(2);
        rst_ni = 1'b1;
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        idle(4);
        chk("mrst_nopulse", done_pulses - pulses_before, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_trdb_trace_fifo
